// File: rtl/sel_pkg.sv
// Shared definitions for the operand selector: buffer-state encoding, the
// per-result flag record and the out-of-range select test.
`timescale 1ns/1ps
package sel_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // Flags stored alongside each buffered result; data width is set per instance.
  typedef struct packed {
    logic zero;
    logic err;
  } sel_flags_t;

  function automatic logic sel_out_of_range(input int unsigned sel, input int unsigned num_in);
    return sel >= num_in;
  endfunction

endpackage

// File: rtl/sel_mux_core.sv
// Combinational N-way operand selection with conditional "take alternate when
// channel 0 is zero" mode, zero flag and out-of-range select flag.
`timescale 1ns/1ps
module sel_mux_core
  import sel_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0]    din,
  input  logic [$clog2(NUM_IN)-1:0]  sel,
  input  logic                       cond_en,
  output logic [WIDTH-1:0]           value,
  output logic                       zero,
  output logic                       err
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic [WIDTH-1:0] ch0;
  logic [WIDTH-1:0] picked;
  logic             sel_oob;
  logic             take_ch0;

  assign ch0 = din[WIDTH-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    picked = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) picked = din[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oob  = sel_out_of_range(32'(sel), NUM_IN);
  assign take_ch0 = cond_en && (ch0 != '0);

  always_comb begin
    value = '0;
    if (take_ch0)      value = ch0;
    else if (!sel_oob) value = picked;
  end

  // A non-zero channel 0 in conditional mode masks any bad select.
  assign err  = !take_ch0 && sel_oob;
  assign zero = (value == '0);

endmodule

// File: rtl/sel_mux_pipe.sv
// Operand selector with a registered valid/ready output stage backed by a
// 2-entry skid buffer; in_ready depends only on buffer state.
`timescale 1ns/1ps
module sel_mux_pipe
  import sel_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_IN*WIDTH-1:0]    din,
  input  logic [$clog2(NUM_IN)-1:0]  sel,
  input  logic                       cond_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    sel_flags_t       flags;
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  logic [WIDTH-1:0] cand_data;
  logic             cand_zero;
  logic             cand_err;
  logic             accept;
  logic             emit;

  sel_mux_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_core (
    .din     (din),
    .sel     (sel),
    .cond_en (cond_en),
    .value   (cand_data),
    .zero    (cand_zero),
    .err     (cand_err)
  );

  assign new_entry = {cand_data, cand_zero, cand_err};

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // NOTE: skid contents need no reset; they are only read after a fresh load
  // moves the buffer to TWO, and state_q alone marks the entry as valid.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign out_data = main_q.data;
  assign out_zero = main_q.flags.zero;
  assign out_err  = main_q.flags.err;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench: directed scenarios plus a randomized stream scored
// against a queue-based reference of the selector and its 2-deep buffer.
`timescale 1ns/1ps
module tb_sel_mux_pipe;

  typedef struct {
    logic [15:0] v;
    bit          z;
    bit          e;
  } exp_t;

  int errors = 0;
  int checks = 0;

  logic clk, rst;

  // Default instance: WIDTH=16, NUM_IN=2
  logic        in_valid, in_ready, cond_en, out_valid, out_ready, out_zero, out_err;
  logic [31:0] din;
  logic [0:0]  sel;
  logic [15:0] out_data;

  // Non-power-of-two instance: WIDTH=8, NUM_IN=3
  logic        iv3, ir3, cond3, ov3, or3, oz3, oe3;
  logic [23:0] din3;
  logic [1:0]  sel3;
  logic [7:0]  od3;

  exp_t q16[$];
  exp_t q3[$];

  sel_mux_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .sel(sel), .cond_en(cond_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err)
  );

  sel_mux_pipe #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .din(din3),
    .sel(sel3), .cond_en(cond3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_zero(oz3), .out_err(oe3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Selection rule straight from the behaviour description, on plain integers.
  function automatic exp_t ref_sel(input logic [63:0] d, input int s, input bit c,
                                   input int n, input int w);
    exp_t        r;
    logic [63:0] mask;
    logic [63:0] ch0;
    logic [63:0] v;
    mask = (64'd1 << w) - 64'd1;
    ch0  = d & mask;
    if (c && ch0 != 0) begin
      v = ch0;   r.e = 1'b0;
    end else if (s >= n) begin
      v = 0;     r.e = 1'b1;
    end else begin
      v = (d >> (s * w)) & mask;
      r.e = 1'b0;
    end
    r.v = v[15:0];
    r.z = (v == 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; din = 32'h5555_AAAA; sel = 1'b0; cond_en = 1'b0; out_ready = 1'b0;
    iv3 = 1'b1; din3 = 24'h123456; sel3 = 2'd0; cond3 = 1'b0; or3 = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, out_data, out_zero, out_err} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got v/rdy/d/z/e=%b/%b/%h/%b/%b required 0/1/0000/0/0",
               out_valid, in_ready, out_data, out_zero, out_err);
    end
    checks++;
    if ({ov3, ir3, od3, oz3, oe3} !== {1'b0, 1'b1, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8: got v/rdy/d/z/e=%b/%b/%h/%b/%b required 0/1/00/0/0",
               ov3, ir3, od3, oz3, oe3);
    end
    rst = 1'b0; in_valid = 1'b0; iv3 = 1'b0;
  endtask

  task automatic test_direct();
    out_ready = 1'b1;
    in_valid = 1'b1; din = {16'h1234, 16'h0000}; sel = 1'b1; cond_en = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_data, out_zero, out_err} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL direct_sel1: got v/d/z/e=%b/%h/%b/%b required 1/1234/0/0",
               out_valid, out_data, out_zero, out_err);
    end
    sel = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_data, out_zero, out_err} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL direct_sel0: got v/d/z/e=%b/%h/%b/%b required 1/0000/1/0",
               out_valid, out_data, out_zero, out_err);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL direct_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_cond();
    out_ready = 1'b1;
    in_valid = 1'b1; cond_en = 1'b1; din = {16'hBEEF, 16'h0000}; sel = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_data, out_zero, out_err} !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cond_alt: got v/d/z/e=%b/%h/%b/%b required 1/beef/0/0",
               out_valid, out_data, out_zero, out_err);
    end
    din = {16'hBEEF, 16'h0007}; sel = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_data, out_zero, out_err} !== {1'b1, 16'h0007, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cond_ch0_sel1: got v/d/z/e=%b/%h/%b/%b required 1/0007/0/0",
               out_valid, out_data, out_zero, out_err);
    end
    sel = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 16'h0007}) begin
      errors++;
      $display("FAIL cond_ch0_sel0: got v/d=%b/%h required 1/0007", out_valid, out_data);
    end
    in_valid = 1'b0; cond_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; cond_en = 1'b0; sel = 1'b0;
    in_valid = 1'b1; din = {16'h0, 16'h0001};
    tick();
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL bp_first: got rdy/v/d=%b/%b/%h required 1/1/0001", in_ready, out_valid, out_data);
    end
    din = {16'h0, 16'h0002};
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got in_ready=%b required 0", in_ready);
    end
    din = {16'h0, 16'h0003};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 16'h0001}) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy/v/d=%b/%b/%h required 0/1/0001",
                 i, in_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL bp_second: got rdy/v/d=%b/%b/%h required 1/1/0002", in_ready, out_valid, out_data);
    end
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 16'h0003}) begin
      errors++;
      $display("FAIL bp_third: got v/d=%b/%h required 1/0003", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_num_in3();
    or3 = 1'b1;
    iv3 = 1'b1; din3 = {8'hA5, 8'h33, 8'h00}; sel3 = 2'd2; cond3 = 1'b0;
    tick();
    checks++;
    if ({ov3, od3, oz3, oe3} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL n3_sel2: got v/d/z/e=%b/%h/%b/%b required 1/a5/0/0", ov3, od3, oz3, oe3);
    end
    sel3 = 2'd3;
    tick();
    checks++;
    if ({ov3, od3, oz3, oe3} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL n3_oob_direct: got v/d/z/e=%b/%h/%b/%b required 1/00/1/1", ov3, od3, oz3, oe3);
    end
    cond3 = 1'b1; din3 = {8'hA5, 8'h33, 8'h11};
    tick();
    checks++;
    if ({ov3, od3, oz3, oe3} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL n3_oob_cond_ch0: got v/d/z/e=%b/%h/%b/%b required 1/11/0/0", ov3, od3, oz3, oe3);
    end
    din3 = {8'hA5, 8'h33, 8'h00};
    tick();
    checks++;
    if ({ov3, od3, oz3, oe3} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL n3_oob_cond_zero: got v/d/z/e=%b/%h/%b/%b required 1/00/1/1", ov3, od3, oz3, oe3);
    end
    iv3 = 1'b0; cond3 = 1'b0;
    tick();
    checks++;
    if (ov3 !== 1'b0) begin
      errors++;
      $display("FAIL n3_drain: got out_valid=%b required 0", ov3);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; cond_en = 1'b0; sel = 1'b0;
    in_valid = 1'b1; din = {16'h0, 16'h00AA};
    tick();
    din = {16'h0, 16'h00BB};
    tick();
    checks++;
    if ({in_ready, out_valid} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rmid_full: got rdy/v=%b/%b required 0/1", in_ready, out_valid);
    end
    rst = 1'b1; din = {16'h0, 16'h00CC};
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_data, out_zero, out_err} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_after: got v/rdy/d/z/e=%b/%b/%h/%b/%b required 0/1/0000/0/0",
               out_valid, in_ready, out_data, out_zero, out_err);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale%0d: got out_valid=%b data=%h required 0", i, out_valid, out_data);
      end
    end
  endtask

  // Compare both instances against their queues, then advance the models for
  // the coming edge using only the model's own occupancy.
  task automatic score_cycle(input int cyc);
    exp_t f;
    checks++;
    if (out_valid !== (q16.size() != 0) || in_ready !== (q16.size() < 2)) begin
      errors++;
      $display("FAIL stream16_hs cyc=%0d: got v/rdy=%b/%b required %b/%b", cyc,
               out_valid, in_ready, q16.size() != 0, q16.size() < 2);
    end
    if (q16.size() != 0) begin
      f = q16[0];
      checks++;
      if ({out_data, out_zero, out_err} !== {f.v, f.z, f.e}) begin
        errors++;
        $display("FAIL stream16_data cyc=%0d: got d/z/e=%h/%b/%b required %h/%b/%b", cyc,
                 out_data, out_zero, out_err, f.v, f.z, f.e);
      end
    end
    checks++;
    if (ov3 !== (q3.size() != 0) || ir3 !== (q3.size() < 2)) begin
      errors++;
      $display("FAIL stream8_hs cyc=%0d: got v/rdy=%b/%b required %b/%b", cyc,
               ov3, ir3, q3.size() != 0, q3.size() < 2);
    end
    if (q3.size() != 0) begin
      f = q3[0];
      checks++;
      if ({od3, oz3, oe3} !== {f.v[7:0], f.z, f.e}) begin
        errors++;
        $display("FAIL stream8_data cyc=%0d: got d/z/e=%h/%b/%b required %h/%b/%b", cyc,
                 od3, oz3, oe3, f.v[7:0], f.z, f.e);
      end
    end
    begin
      bit acc16, acc3;
      acc16 = in_valid && (q16.size() < 2);
      acc3  = iv3 && (q3.size() < 2);
      if (out_ready && q16.size() != 0) void'(q16.pop_front());
      if (or3 && q3.size() != 0) void'(q3.pop_front());
      if (acc16) q16.push_back(ref_sel({32'h0, din}, int'(sel), cond_en, 2, 16));
      if (acc3)  q3.push_back(ref_sel({40'h0, din3}, int'(sel3), cond3, 3, 8));
    end
  endtask

  task automatic test_stream();
    q16.delete();
    q3.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      din[15:0]  = ($urandom_range(0, 1) != 0) ? 16'h0 : 16'($urandom);
      din[31:16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      sel        = 1'($urandom);
      cond_en    = 1'($urandom);
      iv3   = ($urandom_range(0, 3) != 0);
      or3   = ($urandom_range(0, 2) != 0);
      din3[7:0]   = ($urandom_range(0, 1) != 0) ? 8'h0 : 8'($urandom);
      din3[15:8]  = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
      din3[23:16] = 8'($urandom);
      sel3  = 2'($urandom_range(0, 3));
      cond3 = 1'($urandom);
      score_cycle(cyc);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; iv3 = 1'b0; or3 = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      score_cycle(1000 + cyc);
      tick();
    end
    checks++;
    if (q16.size() != 0 || q3.size() != 0 || out_valid !== 1'b0 || ov3 !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got left16=%0d left8=%0d v16=%b v8=%b required 0/0/0/0",
               q16.size(), q3.size(), out_valid, ov3);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_cond();
    test_back_to_back();
    test_num_in3();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
